generic_rr_fifo_mux: RTL and testbench
======================================

Name: generic_rr_fifo_mux

Overview:
- Multi-channel ingress merger. CHANNELS producers with valid/ready handshakes are arbitrated into one shared FIFO of depth DEPTH.
- Each FIFO entry carries a WIDTH-bit payload plus the index of the source channel.
- WIDTH defaults to the packed width of the two-field struct used by the generic interface tests. Generic instantiations bind WIDTH to a package constant or a struct width.
- Sits between several request sources and a single downstream consumer.

Parameters:
- WIDTH, 2, payload bits per entry (≥1).
- DEPTH, 4, FIFO entries (≥2; need not be a power of two).
- CHANNELS, 2, number of input channels (≥1).
- RR_MODE, 1, 1 = round-robin arbitration; 0 = fixed priority, lowest index wins.
- Derived: CW = max(1, clog2(CHANNELS)); AW = max(1, clog2(DEPTH)); NW = clog2(DEPTH+1).

Ports:
- i_clk  input  1  clock, all state on rising edge.
- i_rst  input  1  reset, synchronous and active-high.
- i_valid  input  CHANNELS  per-channel request valid.
- o_ready  output  CHANNELS  per-channel accept; at most one bit set.
- i_data  input  CHANNELS*WIDTH  channel k payload at bits [k*WIDTH +: WIDTH].
- o_valid  output  1  FIFO head valid.
- i_ready  input  1  downstream accept.
- o_data  output  WIDTH  head payload.
- o_ch  output  CW  head source channel.
- o_count  output  NW  current occupancy.
- o_full  output  1  o_count == DEPTH.
- o_empty  output  1  o_count == 0.

Behaviour:
- Reset (i_rst high at a clock edge):
  - Write pointer, read pointer, count and round-robin pointer all go to 0.
  - After reset: o_valid=0, o_count=0, o_empty=1, o_full=0, o_data=0, o_ch=0.
  - Storage contents need not be cleared, but o_data/o_ch are masked to 0 while empty.
  - Reset mid-operation discards all entries; no push or pop is performed in the reset cycle.
- Pop:
  - pop = o_valid && i_ready.
  - o_valid = !o_empty.
- Space:
  - space = !o_full || pop.
  - A push is permitted on a full FIFO when a pop occurs in the same cycle.
- Grant (combinational from i_valid and priority pointer):
  - RR_MODE=1: search starts at rr_ptr, upward with wrap; the first valid channel is granted.
  - RR_MODE=0: the lowest-index valid channel is granted.
  - o_ready[g] = space for the granted channel g only; all other o_ready bits are 0.
  - No valid input: o_ready = 0.
  - o_ready is allowed to depend combinationally on i_valid and i_ready.
- Push:
  - push = i_valid[g] && o_ready[g].
  - Writes {g, payload} at the write pointer; the write pointer increments, wrapping DEPTH-1 → 0.
- Round-robin pointer (RR_MODE=1):
  - On push, rr_ptr ← (g+1) mod CHANNELS.
  - Otherwise rr_ptr holds.
  - This gives starvation freedom: a continuously valid channel waits at most CHANNELS-1 accepted pushes.
- Read pointer: on pop, increments with the same wrap.
- Count:
  - push only: +1.
  - pop only: -1.
  - both or neither: unchanged.
- Latency:
  - An entry pushed at edge t appears on o_data/o_ch/o_valid after edge t (one cycle); there is no bypass on empty.
  - Head order is strict FIFO order of acceptance.
- Outputs: o_count, o_full and o_empty derive from registered count only, with no combinational path from inputs.
- Simultaneous push and pop:
  - On an empty FIFO: impossible, since o_valid=0.
  - On a full FIFO: both proceed, count stays DEPTH.
- Producer requirement: i_data must be held while i_valid=1 and not accepted. The block does not depend on this, since the grant may move only after a push.
- CHANNELS=1: o_ch is a constant 0; the arbiter degenerates to a pass-through.

Test Plan:
- Fill/drain: CHANNELS=2, DEPTH=4, only ch0 valid with payloads 0,1,2,3 and i_ready=0.
  - Four pushes accepted; then o_full=1, o_count=4, o_ready=00.
  - Raise i_ready: drains 0,1,2,3 with o_ch=0 over 4 cycles; then o_empty=1.
- Round-robin fairness: RR_MODE=1, CHANNELS=3, all valid continuously, i_ready=1.
  - Accepted o_ch sequence is 0,1,2,0,1,2.
  - Occupancy stays ≤1 once steady.
- Fixed priority: RR_MODE=0, ch0 and ch1 both valid continuously.
  - Only ch0 is accepted until ch0 deasserts; ch1 is accepted the next cycle.
- Full with pop: FIFO full (count 4), ch1 valid, i_ready=1.
  - Push and pop happen in the same cycle; count remains 4.
  - The new entry appears at the tail after the 3 remaining entries.
- Pointer wrap: DEPTH=3, push/pop 7 entries in a staggered pattern.
  - Output order equals input order; o_count never exceeds 3 and never underflows.
- Reset mid-stream: assert i_rst with count=2 and rr_ptr=1.
  - Next cycle: o_valid=0, o_count=0, o_data=0.
  - The next push from all-valid inputs grants ch0.

Source files
------------

// File: rtl/generic_rr_fifo_mux_if.sv
// Handshake bundle for generic_rr_fifo_mux: per-channel ingress, single
// egress and occupancy status.
interface generic_rr_fifo_mux_if #(
    parameter int WIDTH    = 2,
    parameter int DEPTH    = 4,
    parameter int CHANNELS = 2
);
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int NW = $clog2(DEPTH + 1);

    logic [CHANNELS-1:0]       i_valid;
    logic [CHANNELS-1:0]       o_ready;
    logic [CHANNELS*WIDTH-1:0] i_data;
    logic                      o_valid;
    logic                      i_ready;
    logic [WIDTH-1:0]          o_data;
    logic [CW-1:0]             o_ch;
    logic [NW-1:0]             o_count;
    logic                      o_full;
    logic                      o_empty;

    modport slave (
        input  i_valid, i_data, i_ready,
        output o_ready, o_valid, o_data, o_ch, o_count, o_full, o_empty
    );

    modport master (
        output i_valid, i_data, i_ready,
        input  o_ready, o_valid, o_data, o_ch, o_count, o_full, o_empty
    );
endinterface

// File: rtl/generic_rr_fifo_mux.sv
// Arbitrates CHANNELS valid/ready producers into one shared FIFO; each entry
// stores the payload together with the index of the channel it came from.
module generic_rr_fifo_mux #(
    parameter int WIDTH    = 2,
    parameter int DEPTH    = 4,
    parameter int CHANNELS = 2,
    parameter int RR_MODE  = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    generic_rr_fifo_mux_if.slave  bus
);
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int NW = $clog2(DEPTH + 1);
    localparam int EW = CW + WIDTH;

    logic [EW-1:0]    mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [NW-1:0]    count_r;
    logic [CW-1:0]    rr_ptr_r;

    logic [CW-1:0]    grant_s;
    logic             grant_vld_s;
    logic [WIDTH-1:0] payload_s;
    logic             full_s;
    logic             empty_s;
    logic             pop_s;
    logic             space_s;
    logic             push_s;
    logic [EW-1:0]    head_s;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? {AW{1'b0}} : p + AW'(1);
    endfunction

    assign full_s  = (count_r == NW'(DEPTH));
    assign empty_s = (count_r == {NW{1'b0}});
    assign pop_s   = !empty_s && bus.i_ready;
    assign space_s = !full_s || pop_s;
    assign push_s  = grant_vld_s && space_s && !i_rst;

    // Grant: smallest circular distance from the priority base wins
    always_comb begin
        int best_s;
        int dist_s;
        grant_s     = {CW{1'b0}};
        grant_vld_s = 1'b0;
        best_s      = CHANNELS;
        dist_s      = 0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (RR_MODE != 0) begin
                dist_s = (c >= int'(rr_ptr_r)) ? (c - int'(rr_ptr_r))
                                               : (c + CHANNELS - int'(rr_ptr_r));
            end else begin
                dist_s = c;
            end
            if (bus.i_valid[c] && (dist_s < best_s)) begin
                best_s      = dist_s;
                grant_s     = CW'(c);
                grant_vld_s = 1'b1;
            end else begin
                best_s      = best_s;
            end
        end
    end

    // Payload of the granted channel and the one-hot ready vector
    always_comb begin
        payload_s   = {WIDTH{1'b0}};
        bus.o_ready = {CHANNELS{1'b0}};
        for (int c = 0; c < CHANNELS; c++) begin
            if (grant_s == CW'(c)) begin
                payload_s      = bus.i_data[c*WIDTH +: WIDTH];
                bus.o_ready[c] = grant_vld_s && space_s;
            end else begin
                bus.o_ready[c] = 1'b0;
            end
        end
    end

    // Entry storage; deliberately not cleared, the outputs are masked while empty
    always_ff @(posedge i_clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= {grant_s, payload_s};
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    // Pointers, occupancy and round-robin base
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {NW{1'b0}};
            rr_ptr_r <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
                rr_ptr_r <= (grant_s == CW'(CHANNELS - 1)) ? {CW{1'b0}} : grant_s + CW'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
                rr_ptr_r <= rr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + NW'(1);
                2'b01:   count_r <= count_r - NW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign head_s      = mem_r[rd_ptr_r];
    assign bus.o_count = count_r;
    assign bus.o_full  = full_s;
    assign bus.o_empty = empty_s;
    assign bus.o_valid = !empty_s;
    assign bus.o_data  = empty_s ? {WIDTH{1'b0}} : head_s[WIDTH-1:0];
    assign bus.o_ch    = empty_s ? {CW{1'b0}}    : head_s[EW-1:WIDTH];
endmodule

// File: tb/tb_generic_rr_fifo_mux.sv
// Self-checking bench: three configurations driven from one vector table,
// with a scoreboard of {channel, payload} checked in acceptance order.
module tb_generic_rr_fifo_mux;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int         sel = 0;
    logic [2:0] valid = 3'b000;
    logic [7:0] d0 = 8'h00, d1 = 8'h00, d2 = 8'h00;
    logic       rdy = 1'b0;

    // A: 2 ch, depth 4, round robin. B: 3 ch, depth 3, round robin. C: 2 ch, depth 4, fixed.
    generic_rr_fifo_mux_if #(.WIDTH(8), .DEPTH(4), .CHANNELS(2)) ifa();
    generic_rr_fifo_mux_if #(.WIDTH(8), .DEPTH(3), .CHANNELS(3)) ifb();
    generic_rr_fifo_mux_if #(.WIDTH(8), .DEPTH(4), .CHANNELS(2)) ifc();

    generic_rr_fifo_mux #(.WIDTH(8), .DEPTH(4), .CHANNELS(2), .RR_MODE(1)) dut_a (.i_clk(clk), .i_rst(rst), .bus(ifa));
    generic_rr_fifo_mux #(.WIDTH(8), .DEPTH(3), .CHANNELS(3), .RR_MODE(1)) dut_b (.i_clk(clk), .i_rst(rst), .bus(ifb));
    generic_rr_fifo_mux #(.WIDTH(8), .DEPTH(4), .CHANNELS(2), .RR_MODE(0)) dut_c (.i_clk(clk), .i_rst(rst), .bus(ifc));

    assign ifa.i_valid = (sel == 0) ? valid[1:0] : 2'b00;
    assign ifa.i_data  = {d1, d0};
    assign ifa.i_ready = (sel == 0) ? rdy : 1'b0;
    assign ifb.i_valid = (sel == 1) ? valid : 3'b000;
    assign ifb.i_data  = {d2, d1, d0};
    assign ifb.i_ready = (sel == 1) ? rdy : 1'b0;
    assign ifc.i_valid = (sel == 2) ? valid[1:0] : 2'b00;
    assign ifc.i_data  = {d1, d0};
    assign ifc.i_ready = (sel == 2) ? rdy : 1'b0;

    logic [2:0] obs_ready;
    logic       obs_valid, obs_full, obs_empty;
    logic [7:0] obs_data;
    logic [1:0] obs_ch;
    logic [2:0] obs_count;

    always_comb begin
        obs_ready = 3'b000; obs_valid = 1'b0; obs_full = 1'b0; obs_empty = 1'b0;
        obs_data = 8'h00; obs_ch = 2'b00; obs_count = 3'd0;
        case (sel)
            0: begin
                obs_ready = {1'b0, ifa.o_ready}; obs_valid = ifa.o_valid; obs_full = ifa.o_full;
                obs_empty = ifa.o_empty; obs_data = ifa.o_data; obs_ch = {1'b0, ifa.o_ch};
                obs_count = ifa.o_count;
            end
            1: begin
                obs_ready = ifb.o_ready; obs_valid = ifb.o_valid; obs_full = ifb.o_full;
                obs_empty = ifb.o_empty; obs_data = ifb.o_data; obs_ch = ifb.o_ch;
                obs_count = {1'b0, ifb.o_count};
            end
            default: begin
                obs_ready = {1'b0, ifc.o_ready}; obs_valid = ifc.o_valid; obs_full = ifc.o_full;
                obs_empty = ifc.o_empty; obs_data = ifc.o_data; obs_ch = {1'b0, ifc.o_ch};
                obs_count = ifc.o_count;
            end
        endcase
    end

    typedef struct {
        int         sel;
        logic       rst;
        logic [2:0] valid;
        logic [7:0] d0, d1, d2;
        logic       rdy;
        logic [2:0] exp_ready;
        int         exp_count;
    } vec_t;

    vec_t       tbl[$];
    logic [9:0] sb[$];
    int         checks = 0;
    int         errors = 0;

    function automatic vec_t mk(input int s, input logic r, input logic [2:0] v,
                                input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                                input logic rd, input logic [2:0] er, input int ec);
        vec_t t;
        t.sel = s; t.rst = r; t.valid = v; t.d0 = a; t.d1 = b; t.d2 = c;
        t.rdy = rd; t.exp_ready = er; t.exp_count = ec;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // One cycle: drive, compare pre-edge outputs, update the scoreboard, let the edge happen
    task automatic step(input vec_t v);
        logic [9:0] e;
        int         dep;
        @(negedge clk);
        sel = v.sel; rst = v.rst; valid = v.valid; d0 = v.d0; d1 = v.d1; d2 = v.d2; rdy = v.rdy;
        #1;
        dep = (v.sel == 1) ? 3 : 4;
        if (v.rst) begin
            sb.delete();
        end else begin
            chk("o_ready", {29'd0, obs_ready}, {29'd0, v.exp_ready});
            chk("o_count", {29'd0, obs_count}, v.exp_count);
            chk("o_valid", {31'd0, obs_valid}, {31'd0, v.exp_count != 0});
            chk("o_full",  {31'd0, obs_full},  {31'd0, v.exp_count == dep});
            chk("o_empty", {31'd0, obs_empty}, {31'd0, v.exp_count == 0});
            if (v.exp_count == 0) begin
                chk("o_data_masked", {24'd0, obs_data}, 32'd0);
                chk("o_ch_masked",   {30'd0, obs_ch},   32'd0);
            end
            if (obs_valid && v.rdy) begin
                if (sb.size() == 0) begin
                    chk("pop_unexpected", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("o_ch",   {30'd0, obs_ch},   {30'd0, e[9:8]});
                    chk("o_data", {24'd0, obs_data}, {24'd0, e[7:0]});
                end
            end
            if (v.exp_ready[0] && v.valid[0]) sb.push_back({2'd0, v.d0});
            if (v.exp_ready[1] && v.valid[1]) sb.push_back({2'd1, v.d1});
            if (v.exp_ready[2] && v.valid[2]) sb.push_back({2'd2, v.d2});
        end
    endtask

    initial begin
        // A: fill/drain on ch0
        for (int j = 0; j < 4; j++) tbl.push_back(mk(0, 0, 3'b001, 8'(j), 8'h00, 8'h00, 0, 3'b001, j));
        tbl.push_back(mk(0, 0, 3'b001, 8'h04, 8'h00, 8'h00, 0, 3'b000, 4));
        for (int j = 0; j < 4; j++) tbl.push_back(mk(0, 0, 3'b000, 8'h00, 8'h00, 8'h00, 1, 3'b000, 4 - j));
        tbl.push_back(mk(0, 0, 3'b000, 8'h00, 8'h00, 8'h00, 1, 3'b000, 0));
        // A: full with simultaneous pop; new entry lands at the tail
        tbl.push_back(mk(0, 0, 3'b010, 8'h00, 8'h10, 8'h00, 0, 3'b010, 0));
        tbl.push_back(mk(0, 0, 3'b011, 8'h20, 8'h11, 8'h00, 0, 3'b001, 1));
        tbl.push_back(mk(0, 0, 3'b011, 8'h21, 8'h11, 8'h00, 0, 3'b010, 2));
        tbl.push_back(mk(0, 0, 3'b001, 8'h21, 8'h00, 8'h00, 0, 3'b001, 3));
        tbl.push_back(mk(0, 0, 3'b010, 8'h00, 8'h12, 8'h00, 1, 3'b010, 4));
        for (int j = 0; j < 5; j++) tbl.push_back(mk(0, 0, 3'b000, 8'h00, 8'h00, 8'h00, 1, 3'b000, 4 - j));
        // A: reset with count 2 and rr base 1, then all-valid must grant ch0
        tbl.push_back(mk(0, 0, 3'b010, 8'h00, 8'h30, 8'h00, 0, 3'b010, 0));
        tbl.push_back(mk(0, 0, 3'b001, 8'h31, 8'h00, 8'h00, 0, 3'b001, 1));
        tbl.push_back(mk(0, 1, 3'b000, 8'h00, 8'h00, 8'h00, 1, 3'b000, 2));
        tbl.push_back(mk(0, 0, 3'b011, 8'h40, 8'h41, 8'h00, 0, 3'b001, 0));
        tbl.push_back(mk(0, 0, 3'b000, 8'h00, 8'h00, 8'h00, 1, 3'b000, 1));
        tbl.push_back(mk(0, 0, 3'b000, 8'h00, 8'h00, 8'h00, 1, 3'b000, 0));
        // B: round-robin fairness with all three channels valid
        tbl.push_back(mk(1, 0, 3'b111, 8'h50, 8'h60, 8'h70, 1, 3'b001, 0));
        tbl.push_back(mk(1, 0, 3'b111, 8'h51, 8'h60, 8'h70, 1, 3'b010, 1));
        tbl.push_back(mk(1, 0, 3'b111, 8'h51, 8'h61, 8'h70, 1, 3'b100, 1));
        tbl.push_back(mk(1, 0, 3'b111, 8'h51, 8'h61, 8'h71, 1, 3'b001, 1));
        tbl.push_back(mk(1, 0, 3'b111, 8'h52, 8'h61, 8'h71, 1, 3'b010, 1));
        tbl.push_back(mk(1, 0, 3'b111, 8'h52, 8'h62, 8'h71, 1, 3'b100, 1));
        tbl.push_back(mk(1, 0, 3'b000, 8'h00, 8'h00, 8'h00, 1, 3'b000, 1));
        tbl.push_back(mk(1, 0, 3'b000, 8'h00, 8'h00, 8'h00, 1, 3'b000, 0));
        // B: depth-3 pointer wrap, 7 entries staggered
        tbl.push_back(mk(1, 0, 3'b001, 8'h80, 8'h00, 8'h00, 0, 3'b001, 0));
        tbl.push_back(mk(1, 0, 3'b001, 8'h81, 8'h00, 8'h00, 0, 3'b001, 1));
        tbl.push_back(mk(1, 0, 3'b001, 8'h82, 8'h00, 8'h00, 1, 3'b001, 2));
        tbl.push_back(mk(1, 0, 3'b001, 8'h83, 8'h00, 8'h00, 0, 3'b001, 2));
        tbl.push_back(mk(1, 0, 3'b001, 8'h84, 8'h00, 8'h00, 0, 3'b000, 3));
        tbl.push_back(mk(1, 0, 3'b001, 8'h84, 8'h00, 8'h00, 1, 3'b001, 3));
        tbl.push_back(mk(1, 0, 3'b001, 8'h85, 8'h00, 8'h00, 1, 3'b001, 3));
        tbl.push_back(mk(1, 0, 3'b001, 8'h86, 8'h00, 8'h00, 1, 3'b001, 3));
        tbl.push_back(mk(1, 0, 3'b000, 8'h00, 8'h00, 8'h00, 1, 3'b000, 3));
        tbl.push_back(mk(1, 0, 3'b000, 8'h00, 8'h00, 8'h00, 0, 3'b000, 2));
        tbl.push_back(mk(1, 0, 3'b000, 8'h00, 8'h00, 8'h00, 1, 3'b000, 2));
        tbl.push_back(mk(1, 0, 3'b000, 8'h00, 8'h00, 8'h00, 1, 3'b000, 1));
        tbl.push_back(mk(1, 0, 3'b000, 8'h00, 8'h00, 8'h00, 1, 3'b000, 0));
        // C: fixed priority, ch1 only after ch0 drops
        tbl.push_back(mk(2, 0, 3'b011, 8'h90, 8'hA0, 8'h00, 1, 3'b001, 0));
        tbl.push_back(mk(2, 0, 3'b011, 8'h91, 8'hA0, 8'h00, 1, 3'b001, 1));
        tbl.push_back(mk(2, 0, 3'b011, 8'h92, 8'hA0, 8'h00, 1, 3'b001, 1));
        tbl.push_back(mk(2, 0, 3'b010, 8'h00, 8'hA0, 8'h00, 1, 3'b010, 1));
        tbl.push_back(mk(2, 0, 3'b000, 8'h00, 8'h00, 8'h00, 1, 3'b000, 1));
        tbl.push_back(mk(2, 0, 3'b000, 8'h00, 8'h00, 8'h00, 0, 3'b000, 0));

        rst = 1'b1;
        repeat (2) @(posedge clk);
        for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

        // C hand sequence: fill from ch1, stall when full, then drain in four cycles
        for (int j = 0; j < 4; j++) step(mk(2, 0, 3'b010, 8'h00, 8'hB0 + 8'(j), 8'h00, 0, 3'b010, j));
        step(mk(2, 0, 3'b010, 8'h00, 8'hB4, 8'h00, 0, 3'b000, 4));
        for (int j = 0; j < 4; j++) step(mk(2, 0, 3'b000, 8'h00, 8'h00, 8'h00, 1, 3'b000, 4 - j));
        step(mk(2, 0, 3'b000, 8'h00, 8'h00, 8'h00, 0, 3'b000, 0));
        chk("scoreboard_drained", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
